control_cmd_watchdog_framed: RTL and testbench
==============================================

Name: control_cmd_watchdog_framed

Overview:
- Parametrised successor to the command-stream watchdog.
- Assembles SIG_BYTES-byte frames from the control byte stream and compares each complete frame against a signature. A match "kicks" (reloads) a timeout counter.
- On expiry it drives a multi-cycle sys_reset pulse. Also provides arm-on-first-kick, early-warning, frame abort and a saturating bad-frame count.
- Sits between the control-port byte demux and the top-level system reset tree.

Parameters:
- SIG_BYTES, 4, bytes per signature frame (>=1).
- SIG_PATTERN, 32'h5A5A_A5A5, width 8*SIG_BYTES; frame value that counts as a valid kick.
- TIMEOUT_TICKS, 1_000_000, clk cycles from kick to expiry (>=2).
- WARN_TICKS, 1000, warn asserts when remaining <= WARN_TICKS (< TIMEOUT_TICKS).
- RESET_PULSE_TICKS, 16, sys_reset high duration in cycles (>=1).
- ARM_ON_FIRST_KICK, 1, 1: watchdog idle until first valid kick; 0: running from reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  8  command byte.
- enable  in  1  data_in valid this cycle.
- abort  in  1  discard partial frame; byte counter restarts.
- sys_reset  out  1  system reset request pulse.
- done  out  1  one-cycle pulse: frame completed.
- match  out  1  one-cycle pulse with done when frame == SIG_PATTERN.
- armed  out  1  watchdog counting (RUNNING state).
- warn  out  1  armed and remaining <= WARN_TICKS.
- bad_count  out  8  saturating count of completed non-matching frames.

Behaviour:
- Reset (async): all outputs 0, frame shift register 0, byte index 0, counter = TIMEOUT_TICKS, bad_count = 0. WD state = DISARMED if ARM_ON_FIRST_KICK else RUNNING.
- Frame capture:
  - Each enable cycle shifts: shreg <= {shreg, data_in}. The first byte lands most significant.
  - Byte index counts 0..SIG_BYTES-1. On the last byte, the next cycle has done=1 and match=(assembled frame == SIG_PATTERN), and the index wraps to 0.
  - Back-to-back frames are accepted with no dead cycle.
  - done/match are registered: 1-cycle latency after the final enable.
  - abort clears the index and shreg and suppresses done. abort with enable in the same cycle: abort wins and the byte is dropped.
- Bad frames: done & !match increments bad_count, saturating at 255.
- Watchdog FSM:
  - DISARMED:
    - counter held at TIMEOUT_TICKS; armed=0, warn=0.
    - A kick moves to RUNNING with counter = TIMEOUT_TICKS.
  - RUNNING:
    - armed=1; counter decrements by 1 per cycle.
    - Kick (match pulse cycle) reloads the counter to TIMEOUT_TICKS.
    - When counter==0 with no kick that cycle, go to FIRING.
    - Kick in the same cycle as counter==0: kick wins, no fire.
  - FIRING:
    - sys_reset=1 for exactly RESET_PULSE_TICKS cycles, starting the cycle after counter hits 0; armed=0, warn=0.
    - Kicks are ignored (done/match/bad_count still update).
    - Then sys_reset=0 and the FSM goes to DISARMED (ARM_ON_FIRST_KICK=1) or RUNNING with counter reloaded (ARM_ON_FIRST_KICK=0).
- Widths:
  - Counter width $clog2(TIMEOUT_TICKS+1).
  - Pulse counter width $clog2(RESET_PULSE_TICKS+1).
  - Index width max(1,$clog2(SIG_BYTES)).
  - All comparisons are explicitly sized; no wrap below 0.
- warn is registered and is combinationally consistent with the counter value of the same cycle.
- Reset asserted mid-frame or mid-pulse: immediate return to reset values; sys_reset drops asynchronously.

Test Plan:
Common configuration: SIG_BYTES=2, SIG_PATTERN=16'hA55A, TIMEOUT_TICKS=20, WARN_TICKS=5, RESET_PULSE_TICKS=4, ARM_ON_FIRST_KICK=1.
- Idle after reset, 100 cycles, no input -> armed=0, sys_reset never asserts, bad_count=0.
- Bytes A5,5A on consecutive cycles -> done=match=1 the cycle after 5A. Next cycle armed=1; warn rises when counter=5; counter reaches 0 about 21 cycles later; sys_reset high exactly 4 cycles; then armed=0.
- Armed, kick A5,5A every 15 cycles for 200 cycles -> sys_reset never asserts, warn never asserts.
- Bytes 12,34 then A5,abort,5A,A5,5A -> the first frame gives done=1, match=0, bad_count=1. The aborted frame produces no done. The final frame gives match=1.
- 300 non-matching frames -> bad_count saturates at 255.
- Arrange the kick's match pulse on the same cycle the counter reads 0 -> no sys_reset, counter=20. Then assert reset during a sys_reset pulse -> sys_reset=0 immediately, armed=0.

Source files
------------

// File: rtl/control_cmd_watchdog_framed.sv
// Command-stream watchdog: assembles SIG_BYTES-byte frames, reloads a timeout on a
// signature match and drives a multi-cycle sys_reset pulse when the timeout expires.
//   state       | meaning
//   WD_DISARMED | idle, waiting for the first valid kick
//   WD_RUNNING  | counting down towards expiry
//   WD_FIRING   | sys_reset pulse in progress, kicks ignored
module control_cmd_watchdog_framed #(
  parameter int                     SIG_BYTES         = 4,
  parameter logic [8*SIG_BYTES-1:0] SIG_PATTERN       = 32'h5A5A_A5A5,
  parameter int                     TIMEOUT_TICKS     = 1_000_000,
  parameter int                     WARN_TICKS        = 1000,
  parameter int                     RESET_PULSE_TICKS = 16,
  parameter bit                     ARM_ON_FIRST_KICK = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       enable,
  input  logic       abort,
  output logic       sys_reset,
  output logic       done,
  output logic       match,
  output logic       armed,
  output logic       warn,
  output logic [7:0] bad_count
);

  localparam int FW = 8 * SIG_BYTES;
  localparam int CW = $clog2(TIMEOUT_TICKS + 1);
  localparam int PW = $clog2(RESET_PULSE_TICKS + 1);
  localparam int IW = (SIG_BYTES > 1) ? $clog2(SIG_BYTES) : 1;

  localparam logic [CW-1:0] TIMEOUT_C  = CW'(TIMEOUT_TICKS);
  localparam logic [CW-1:0] WARN_C     = CW'(WARN_TICKS);
  localparam logic [PW-1:0] PULSE_C    = PW'(RESET_PULSE_TICKS);
  localparam logic [IW-1:0] IDX_LAST   = IW'(SIG_BYTES - 1);

  typedef enum logic [1:0] {WD_DISARMED, WD_RUNNING, WD_FIRING} wd_state_t;

  localparam wd_state_t WD_START = ARM_ON_FIRST_KICK ? WD_DISARMED : WD_RUNNING;

  logic [FW-1:0] shreg;
  logic [FW-1:0] shreg_shift;
  logic [IW-1:0] idx;

  wd_state_t     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [PW-1:0] pcnt, pcnt_nx;

  // shift form keeps the single-byte frame case legal
  assign shreg_shift = (shreg << 8) | FW'(data_in);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg     <= '0;
      idx       <= '0;
      done      <= 1'b0;
      match     <= 1'b0;
      bad_count <= '0;
    end else begin
      done  <= 1'b0;
      match <= 1'b0;
      if (abort) begin
        shreg <= '0;
        idx   <= '0;
      end else if (enable) begin
        shreg <= shreg_shift;
        if (idx == IDX_LAST) begin
          idx   <= '0;
          done  <= 1'b1;
          match <= (shreg_shift == SIG_PATTERN);
          if ((shreg_shift != SIG_PATTERN) && (bad_count != 8'hFF))
            bad_count <= bad_count + 8'd1;
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end

  // the registered match pulse is the kick
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pcnt_nx  = pcnt;
    case (state)
      WD_DISARMED: begin
        cnt_nx = TIMEOUT_C;
        if (match) state_nx = WD_RUNNING;
      end
      WD_RUNNING: begin
        if (match) begin
          cnt_nx = TIMEOUT_C;
        end else if (cnt == '0) begin
          state_nx = WD_FIRING;
          pcnt_nx  = PULSE_C;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      WD_FIRING: begin
        if (pcnt == PW'(1)) begin
          pcnt_nx  = '0;
          cnt_nx   = TIMEOUT_C;
          state_nx = WD_START;
        end else begin
          pcnt_nx = pcnt - PW'(1);
        end
      end
      default: begin
        state_nx = WD_START;
        cnt_nx   = TIMEOUT_C;
        pcnt_nx  = '0;
      end
    endcase
  end

  // outputs registered from next-state so they match state/counter in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= WD_START;
      cnt       <= TIMEOUT_C;
      pcnt      <= '0;
      sys_reset <= 1'b0;
      armed     <= 1'b0;
      warn      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pcnt      <= pcnt_nx;
      sys_reset <= (state_nx == WD_FIRING);
      armed     <= (state_nx == WD_RUNNING);
      warn      <= (state_nx == WD_RUNNING) && (cnt_nx <= WARN_C);
    end
  end

endmodule

// File: tb/tb_control_cmd_watchdog_framed.sv
// Bench for control_cmd_watchdog_framed: fixed vector table, directed timing sequences
// and random traffic checked against a timestamp-based reference model.
module tb_control_cmd_watchdog_framed;

  localparam int          SB      = 2;
  localparam logic [15:0] PAT     = 16'hA55A;
  localparam int          TMO     = 20;
  localparam int          WRN     = 5;
  localparam int          RPT     = 4;
  localparam bit          ARM     = 1'b1;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       enable;
  logic       abort;
  logic       sys_reset, done, match, armed, warn;
  logic [7:0] bad_count;

  control_cmd_watchdog_framed #(
    .SIG_BYTES(SB), .SIG_PATTERN(PAT), .TIMEOUT_TICKS(TMO), .WARN_TICKS(WRN),
    .RESET_PULSE_TICKS(RPT), .ARM_ON_FIRST_KICK(ARM)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .enable(enable), .abort(abort),
    .sys_reset(sys_reset), .done(done), .match(match), .armed(armed), .warn(warn),
    .bad_count(bad_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: byte queue for framing, absolute cycle stamps for the watchdog
  logic [7:0] q[$];
  int  k;
  int  mode;      // 0 idle, 1 running, 2 firing
  int  expire;    // cycle whose remaining time is zero
  int  fire_end;  // last cycle of the reset pulse
  bit  exp_done, exp_match;
  int  exp_bad;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, k, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    k = 0; mode = ARM ? 0 : 1; expire = TMO; fire_end = 0;
    exp_done = 0; exp_match = 0; exp_bad = 0;
  endtask

  task automatic model_advance(input bit en, input logic [7:0] d, input bit ab);
    bit prev_match;
    int val;
    prev_match = exp_match;
    k++;
    exp_done = 0; exp_match = 0;
    if (ab) q.delete();
    else if (en) begin
      q.push_back(d);
      if (q.size() == SB) begin
        val = 0;
        foreach (q[i]) val = (val << 8) | int'(q[i]);
        exp_done  = 1;
        exp_match = (val == int'(PAT));
        if (!exp_match && exp_bad < 255) exp_bad++;
        q.delete();
      end
    end
    case (mode)
      0: if (prev_match) begin mode = 1; expire = k + TMO; end
      1: if (prev_match) expire = k + TMO;
         else if (k - 1 == expire) begin mode = 2; fire_end = k + RPT - 1; end
      default: if (k - 1 == fire_end) begin
                 mode = ARM ? 0 : 1;
                 expire = k + TMO;
               end
    endcase
  endtask

  task automatic check_model();
    check("sys_reset", int'(sys_reset), int'(mode == 2));
    check("armed",     int'(armed),     int'(mode == 1));
    check("warn",      int'(warn),      int'(mode == 1 && (expire - k) <= WRN));
    check("done",      int'(done),      int'(exp_done));
    check("match",     int'(match),     int'(exp_match));
    check("bad_count", int'(bad_count), exp_bad);
  endtask

  task automatic step(input bit en, input logic [7:0] d, input bit ab);
    enable = en; data_in = d; abort = ab;
    @(posedge clk); #1;
    model_advance(en, d, ab);
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; data_in = 8'h00; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("rst_sys_reset", int'(sys_reset), 0);
    check("rst_armed",     int'(armed),     0);
    check("rst_done",      int'(done),      0);
    check("rst_bad",       int'(bad_count), 0);
  endtask

  typedef struct {
    bit         en;
    logic [7:0] d;
    bit         ab;
    bit         done;
    bit         match;
    int         bad;
  } vec_t;

  vec_t tbl[10];

  int cnt_sr, cnt_arm, cnt_warn, first_warn, first_sr;
  logic [7:0] b0, b1;

  initial begin
    tbl[0] = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 0};
    tbl[1] = '{1'b1, 8'h34, 1'b0, 1'b1, 1'b0, 1};
    tbl[2] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1};
    tbl[4] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1};
    tbl[5] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 1};
    tbl[6] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1};
    tbl[7] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1};
    tbl[8] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1};
    tbl[9] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 1};

    // idle after reset
    do_reset();
    cnt_sr = 0; cnt_arm = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 8'h00, 1'b0);
      cnt_sr += int'(sys_reset);
      cnt_arm += int'(armed);
    end
    check("idle_sys_reset_cycles", cnt_sr, 0);
    check("idle_armed_cycles", cnt_arm, 0);

    // frame table: bad frame, abort, abort+enable drop, good frames
    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].d, tbl[i].ab);
      check($sformatf("tbl%0d_done", i),  int'(done),      int'(tbl[i].done));
      check($sformatf("tbl%0d_match", i), int'(match),     int'(tbl[i].match));
      check($sformatf("tbl%0d_bad", i),   int'(bad_count), tbl[i].bad);
    end

    // single kick then expiry: match at 2, warn from 18, pulse 24..27
    do_reset();
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'h5A, 1'b0);
    check("kick_done", int'(done), 1);
    check("kick_match", int'(match), 1);
    step(1'b0, 8'h00, 1'b0);
    check("armed_after_kick", int'(armed), 1);
    cnt_sr = 0; first_warn = -1; first_sr = -1;
    while (k < 30) begin
      step(1'b0, 8'h00, 1'b0);
      if (warn && first_warn < 0) first_warn = k;
      if (sys_reset && first_sr < 0) first_sr = k;
      cnt_sr += int'(sys_reset);
    end
    check("first_warn_cycle", first_warn, 18);
    check("first_sys_reset_cycle", first_sr, 24);
    check("sys_reset_width", cnt_sr, RPT);
    check("armed_after_fire", int'(armed), 0);

    // periodic kicks every 15 cycles
    cnt_sr = 0; cnt_warn = 0;
    for (int i = 0; i < 200; i++) begin
      if (i % 15 == 0)      step(1'b1, 8'hA5, 1'b0);
      else if (i % 15 == 1) step(1'b1, 8'h5A, 1'b0);
      else                  step(1'b0, 8'h00, 1'b0);
      cnt_sr += int'(sys_reset);
      cnt_warn += int'(warn);
    end
    check("periodic_sys_reset_cycles", cnt_sr, 0);
    check("periodic_warn_cycles", cnt_warn, 0);

    // kick landing exactly on counter==0, then reset mid-pulse
    do_reset();
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'h5A, 1'b0);
    idle(19);
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'h5A, 1'b0);
    check("edge_kick_match_cycle", k, 23);
    check("edge_kick_match", int'(match), 1);
    idle(21);
    check("edge_no_fire_k44", int'(sys_reset), 0);
    check("edge_armed_k44", int'(armed), 1);
    step(1'b0, 8'h00, 1'b0);
    check("edge_fire_k45", int'(sys_reset), 1);
    step(1'b0, 8'h00, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_reset_sys_reset", int'(sys_reset), 0);
    check("async_reset_armed", int'(armed), 0);
    do_reset();

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      int r;
      logic [7:0] d;
      r = int'($urandom_range(0, 9));
      d = (r < 4) ? 8'hA5 : (r < 8) ? 8'h5A : 8'($urandom);
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 15) == 0);
    end

    // 300 non-matching frames saturate bad_count
    do_reset();
    for (int f = 0; f < 300; f++) begin
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      if ({b0, b1} == PAT) b1 = ~b1;
      step(1'b1, b0, 1'b0);
      if ($urandom_range(0, 15) == 0) begin
        step(1'b1, 8'($urandom), 1'b1);
        step(1'b1, b0, 1'b0);
      end
      if ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom), 1'b0);
      step(1'b1, b1, 1'b0);
    end
    step(1'b0, 8'h00, 1'b0);
    check("bad_count_saturated", int'(bad_count), 255);
    check("bad_frames_never_armed", int'(armed), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
